// File: rtl/accumulate_ctrl32.sv
// -----------------------------------------------------------------------------
// accumulate_ctrl32
//
// Sequential accumulator wrapped around a WIDTH-bit ripple-carry adder.
// A burst of `len` operands is accepted over a valid/ready handshake. Each
// accepted beat drives the adder with a = running sum and b = operand (cin = 0).
// The adder sum and carry-out are registered into the accumulator, a sticky
// overflow flag and a saturating carry counter. A one-cycle done pulse marks
// the end of the burst.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      begin burst (only looked at in IDLE)
//   len        in   CNT_W  operands in burst, captured with start
//   in_valid   in   1      operand valid
//   in_data    in   WIDTH  operand
//   in_ready   out  1      operand can be accepted this cycle
//   sum        out  WIDTH  accumulated sum, modulo 2^WIDTH
//   carry_cnt  out  CNT_W  count of beats with adder cout=1, saturating
//   overflow   out  1      sticky: some beat produced cout=1
//   busy       out  1      high while accumulating
//   done       out  1      one-cycle pulse after the last beat
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// accumulate_ctrl32_rca
//
// Plain ripple-carry adder: one full adder per bit, carry chained LSB to MSB.
//
// Ports
//   i_a, i_b   in   WIDTH  addends
//   i_cin      in   1      carry into bit 0
//   o_s        out  WIDTH  sum bits
//   o_cout     out  1      carry out of the MSB
// -----------------------------------------------------------------------------
module accumulate_ctrl32_rca #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_fa
            logic w_p;
            assign w_p        = i_a[g] ^ i_b[g];
            assign o_s[g]     = w_p ^ w_c[g];
            assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & w_p);
        end
    endgenerate

    assign o_cout = w_c[WIDTH];

endmodule

module accumulate_ctrl32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [WIDTH-1:0] r_sum_p1;
    logic [CNT_W-1:0] r_carry_cnt_p1;
    logic             r_overflow_p1;
    logic [CNT_W-1:0] r_remaining;
    logic             r_busy;
    logic             r_done;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_last_beat;
    logic [WIDTH-1:0] w_add_s;
    logic             w_add_cout;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             inc
    );
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + CNT_ONE;
        end
        return cnt;
    endfunction

    // Ready is a pure state decode so the producer sees it in the same cycle.
    assign w_in_ready  = (r_state == S_ACCUM);
    assign w_accept    = in_valid & w_in_ready;
    assign w_last_beat = (r_remaining == CNT_ONE);

    accumulate_ctrl32_rca #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (r_sum_p1),
        .i_b    (in_data),
        .i_cin  (1'b0),
        .o_s    (w_add_s),
        .o_cout (w_add_cout)
    );

    // ---- stage p1: adder result registered on each accepted beat ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_sum_p1       <= '0;
            r_carry_cnt_p1 <= '0;
            r_overflow_p1  <= 1'b0;
            r_remaining    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sum_p1       <= '0;
                        r_carry_cnt_p1 <= '0;
                        r_overflow_p1  <= 1'b0;
                        r_remaining    <= len;
                        if (len != '0) begin
                            r_state <= S_ACCUM;
                            r_busy  <= 1'b1;
                        end else begin
                            // Empty burst still produces its done pulse.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_ACCUM: begin
                    if (w_accept) begin
                        r_sum_p1       <= w_add_s;
                        r_overflow_p1  <= r_overflow_p1 | w_add_cout;
                        r_carry_cnt_p1 <= sat_inc(r_carry_cnt_p1, w_add_cout);
                        r_remaining    <= r_remaining - CNT_ONE;
                        if (w_last_beat) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign sum       = r_sum_p1;
    assign carry_cnt = r_carry_cnt_p1;
    assign overflow  = r_overflow_p1;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_accumulate_ctrl32.sv
// -----------------------------------------------------------------------------
// tb_accumulate_ctrl32
//
// Directed bench for accumulate_ctrl32. A transaction-level model tracks the
// expected burst phase, sum, carry count and overflow from the input stream;
// a negedge compare process checks every DUT output against it each cycle,
// and literal expectations after each scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_accumulate_ctrl32;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] carry_cnt;
    logic             overflow;
    logic             busy;
    logic             done;

    int n_vec  = 0;
    int n_fail = 0;

    accumulate_ctrl32 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry_cnt (carry_cnt),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = waiting for start, 1 = taking operands, 2 = reporting done
    int          m_phase = 0;
    bit          m_known = 1'b0;
    logic [63:0] m_sum   = 64'd0;
    int          m_carry = 0;
    bit          m_ovf   = 1'b0;
    int          m_left  = 0;

    always @(posedge clk) begin
        logic [63:0] t;
        if (reset) begin
            m_known = 1'b1;
            m_phase = 0;
            m_sum   = 64'd0;
            m_carry = 0;
            m_ovf   = 1'b0;
            m_left  = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_sum   = 64'd0;
                m_carry = 0;
                m_ovf   = 1'b0;
                m_left  = int'(len);
                m_phase = (len != 0) ? 1 : 2;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                t = m_sum + {32'd0, in_data};
                m_sum = t & 64'h0000_0000_FFFF_FFFF;
                if (t >= 64'h1_0000_0000) begin
                    m_ovf = 1'b1;
                    if (m_carry < 255) m_carry = m_carry + 1;
                end
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("cyc_sum",       {32'd0, sum},          m_sum);
            chk("cyc_carry_cnt", {56'd0, carry_cnt},    64'(m_carry));
            chk("cyc_overflow",  {63'd0, overflow},     {63'd0, m_ovf});
            chk("cyc_in_ready",  {63'd0, in_ready},     {63'd0, (m_phase == 1)});
            chk("cyc_busy",      {63'd0, busy},         {63'd0, (m_phase == 1)});
            chk("cyc_done",      {63'd0, done},         {63'd0, (m_phase == 2)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;

        // 1: reset state
        idle(2);
        chk("rst_sum",      {32'd0, sum},       64'd0);
        chk("rst_overflow", {63'd0, overflow},  64'd0);
        chk("rst_carry",    {56'd0, carry_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready},  64'd0);
        chk("rst_busy",     {63'd0, busy},      64'd0);
        chk("rst_done",     {63'd0, done},      64'd0);
        reset = 1'b0;
        idle(1);

        // 2: three back-to-back beats, no carries
        start_burst(3);
        send(32'h0080_0800);
        send(32'h0002_0000);
        send(32'h0010_0000);
        chk("t2_sum",      {32'd0, sum},       64'h0092_0800);
        chk("t2_overflow", {63'd0, overflow},  64'd0);
        chk("t2_carry",    {56'd0, carry_cnt}, 64'd0);
        chk("t2_done",     {63'd0, done},      64'd1);
        tick();
        chk("t2_done_end", {63'd0, done},      64'd0);
        idle(1);

        // 3: wrap-around produces one carry
        start_burst(2);
        send(32'hFFFF_FFFF);
        chk("t3_mid_sum",  {32'd0, sum},       64'hFFFF_FFFF);
        send(32'h0000_0002);
        chk("t3_sum",      {32'd0, sum},       64'h0000_0001);
        chk("t3_overflow", {63'd0, overflow},  64'd1);
        chk("t3_carry",    {56'd0, carry_cnt}, 64'd1);
        chk("t3_done",     {63'd0, done},      64'd1);
        tick();

        // 4: empty burst; in_valid held high outside ACCUM must be ignored
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        tick();
        chk("t4_idle_hold", {32'd0, sum},      64'h0000_0001);
        start_burst(0);
        chk("t4_done",     {63'd0, done},      64'd1);
        chk("t4_sum",      {32'd0, sum},       64'd0);
        chk("t4_ready",    {63'd0, in_ready},  64'd0);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk("t4_done_end", {63'd0, done},      64'd0);
        idle(1);

        // 5: gaps of three idle cycles, start pulsed mid-burst
        start_burst(2);
        idle(1);
        start = 1'b1;
        len   = 8'd5;
        tick();
        start = 1'b0;
        len   = '0;
        idle(1);
        send(32'h0200_0800);
        chk("t5_no_early_done", {63'd0, done}, 64'd0);
        idle(3);
        send(32'h0000_0080);
        chk("t5_sum",      {32'd0, sum},       64'h0200_0880);
        chk("t5_done",     {63'd0, done},      64'd1);
        tick();
        chk("t5_idle",     {63'd0, busy},      64'd0);

        // 6: reset mid-burst, then a fresh one-beat burst
        start_burst(4);
        send(32'h0000_0001);
        send(32'h0000_0002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_sum",  {32'd0, sum},       64'd0);
        chk("t6_rst_busy", {63'd0, busy},      64'd0);
        chk("t6_rst_done", {63'd0, done},      64'd0);
        tick();
        chk("t6_no_done",  {63'd0, done},      64'd0);
        start_burst(1);
        send(32'h0000_0010);
        chk("t6_sum",      {32'd0, sum},       64'h0000_0010);
        chk("t6_done",     {63'd0, done},      64'd1);
        tick();

        // 7: maximum length burst of all-ones operands
        start_burst(255);
        for (int i = 0; i < 255; i++) send(32'hFFFF_FFFF);
        chk("t7_sum",      {32'd0, sum},       64'hFFFF_FF01);
        chk("t7_carry",    {56'd0, carry_cnt}, 64'd254);
        chk("t7_overflow", {63'd0, overflow},  64'd1);
        chk("t7_done",     {63'd0, done},      64'd1);
        idle(2);
        chk("t7_hold_sum", {32'd0, sum},       64'hFFFF_FF01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
